muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that reuses the existing 32-bit combinational ALU instead of a dedicated multiplier or divider array.
- Sits beside the execute stage and owns the ALU's func/op1/op2 inputs through an internal mux.
  - Idle: pipeline ALU requests pass straight through.
  - Busy: the sequencer drives ADD/SUB/SLTU micro-ops.
- Returns one 32-bit result per request over a valid/ready handshake.

---
 rtl/muldiv_seq_pkg.sv | 45 ++++
 rtl/muldiv_alu_mux.sv | 34 +++
 rtl/muldiv_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - ALU function codes the sequencer issues to the shared 32-bit ALU
//   - request opcode encoding seen on req_op
//   - sequencer state enum
//   - small opcode decode helpers used at request accept

package muldiv_seq_pkg;

    localparam logic [3:0] ALU_ZERO = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIVU = 3'd1;
    localparam logic [2:0] OP_REMU = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_REM  = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        MUL_IT  = 3'd2,
        DIV_CMP = 3'd3,
        DIV_SUB = 3'd4,
        POST    = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Anything that is not one of the four divide opcodes runs the multiply
    // path, so undefined codes still complete with a response.
    function automatic logic is_mul_op(input logic [2:0] op);
        return !(op == OP_DIVU || op == OP_REMU || op == OP_DIV || op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return (op == OP_REMU) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_alu_mux.sv
// muldiv_alu_mux
// Combinational owner-select for the shared ALU inputs. While the sequencer
// is idle the execute stage's request passes straight through; while it is
// busy the sequencer's micro-op drives the ALU instead.
// Ports:
//   seq_own              1 = sequencer owns the ALU
//   pipe_func/op1/op2    pipeline ALU request
//   seq_func/op1/op2     sequencer micro-op
//   alu_func/op1/op2     to the ALU

module muldiv_alu_mux #(
    parameter int DataWidth = 32
) (
    input  logic                 seq_own,
    input  logic [3:0]           pipe_func,
    input  logic [DataWidth-1:0] pipe_op1,
    input  logic [DataWidth-1:0] pipe_op2,
    input  logic [3:0]           seq_func,
    input  logic [DataWidth-1:0] seq_op1,
    input  logic [DataWidth-1:0] seq_op2,
    output logic [3:0]           alu_func,
    output logic [DataWidth-1:0] alu_op1,
    output logic [DataWidth-1:0] alu_op2
);

    // Pure 2:1 select; the pipeline stalls on busy, so its inputs are
    // simply dropped while the sequencer owns the ALU.
    always_comb begin
        alu_func = seq_own ? seq_func : pipe_func;
        alu_op1  = seq_own ? seq_op1  : pipe_op1;
        alu_op2  = seq_own ? seq_op2  : pipe_op2;
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide sequencer that borrows the execute-stage ALU.
// MUL is shift-and-add (one iteration per multiplier bit up to its MSB),
// DIVU/REMU is restoring division in a compare/subtract pair per bit.
// Optional macro MULDIV_SIGNED_EN: makes ops 4/5 signed via PRE (operand
// negation) and POST (result negation) states; without it ops 4/5 behave
// as DIVU/REMU.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       abort in-flight operation, no response
//   req_valid/req_ready         request handshake; req_op/req_a/req_b
//   resp_valid/resp_data        one-cycle registered result pulse
//   busy                        high whenever not IDLE
//   pipe_func/pipe_op1/pipe_op2 pipeline ALU request, forwarded when idle
//   alu_func/alu_op1/alu_op2    to the shared ALU; alu_result from it

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [DataWidth-1:0] req_a,
    input  logic [DataWidth-1:0] req_b,
    output logic                 resp_valid,
    output logic [DataWidth-1:0] resp_data,
    output logic                 busy,
    input  logic [3:0]           pipe_func,
    input  logic [DataWidth-1:0] pipe_op1,
    input  logic [DataWidth-1:0] pipe_op2,
    output logic [3:0]           alu_func,
    output logic [DataWidth-1:0] alu_op1,
    output logic [DataWidth-1:0] alu_op2,
    input  logic [DataWidth-1:0] alu_result
);

    localparam int CntW = $clog2(DataWidth);

    state_t               state;
    logic [DataWidth-1:0] acc, rem, q, mcand, mplier, divisor;
    logic [CntW-1:0]      cnt;
    logic                 top, lt;
    logic                 op_mul, op_rem;
    logic [DataWidth-1:0] shift_in;
    logic                 do_sub;
    logic [3:0]           seq_func;
    logic [DataWidth-1:0] seq_op1, seq_op2;
`ifdef MULDIV_SIGNED_EN
    logic                 op_signed, neg_q, neg_r, pre_step;
    logic                 post_neg;
    logic [DataWidth-1:0] post_sel;
`endif

    // Handshake status and the next partial-remainder bit derived straight
    // from registers. top holds the bit shifted out of rem so a 33-bit
    // partial remainder still compares correctly against large divisors.
    assign req_ready = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);
    assign shift_in  = {rem[DataWidth-2:0], q[DataWidth-1]};
    assign do_sub    = top || !lt;
`ifdef MULDIV_SIGNED_EN
    assign post_sel  = op_rem ? rem : q;
    assign post_neg  = op_rem ? neg_r : neg_q;
`endif

    // Micro-op issued to the ALU in each busy state. States that do not
    // need an arithmetic result drive ZERO so the ALU sees a quiet request.
    always_comb begin
        seq_func = ALU_ZERO;
        seq_op1  = '0;
        seq_op2  = '0;
        case (state)
            MUL_IT: begin
                seq_func = mplier[0] ? ALU_ADD : ALU_ZERO;
                seq_op1  = acc;
                seq_op2  = mcand;
            end
            DIV_CMP: begin
                seq_func = ALU_SLTU;
                seq_op1  = shift_in;
                seq_op2  = divisor;
            end
            DIV_SUB: begin
                seq_func = do_sub ? ALU_SUB : ALU_ZERO;
                seq_op1  = rem;
                seq_op2  = divisor;
            end
`ifdef MULDIV_SIGNED_EN
            PRE: begin
                seq_func = (pre_step ? divisor[DataWidth-1] : neg_r) ? ALU_SUB : ALU_ZERO;
                seq_op2  = pre_step ? divisor : q;
            end
            POST: begin
                seq_func = post_neg ? ALU_SUB : ALU_ZERO;
                seq_op2  = post_sel;
            end
`endif
            default: begin
                seq_func = ALU_ZERO;
            end
        endcase
    end

    muldiv_alu_mux #(.DataWidth(DataWidth)) u_alu_mux (
        .seq_own   (busy),
        .pipe_func (pipe_func),
        .pipe_op1  (pipe_op1),
        .pipe_op2  (pipe_op2),
        .seq_func  (seq_func),
        .seq_op1   (seq_op1),
        .seq_op2   (seq_op2),
        .alu_func  (alu_func),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2)
    );

    // Sequencer FSM and datapath registers. resp_data is loaded on the edge
    // that enters DONE, so it is stable for the whole resp_valid cycle and
    // held afterwards. flush aborts every busy state except DONE, whose
    // response is already committed; DONE always returns to IDLE anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            acc        <= '0;
            rem        <= '0;
            q          <= '0;
            mcand      <= '0;
            mplier     <= '0;
            divisor    <= '0;
            cnt        <= '0;
            top        <= 1'b0;
            lt         <= 1'b0;
            op_mul     <= 1'b0;
            op_rem     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            op_signed  <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            pre_step   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (flush && state != IDLE && state != DONE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            op_mul  <= is_mul_op(req_op);
                            op_rem  <= is_rem_op(req_op);
                            acc     <= '0;
                            mcand   <= req_a;
                            mplier  <= req_b;
                            q       <= req_a;
                            rem     <= '0;
                            divisor <= req_b;
                            cnt     <= '0;
                            top     <= 1'b0;
                            lt      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                            op_signed <= is_signed_op(req_op);
                            neg_q     <= req_a[DataWidth-1] ^ req_b[DataWidth-1];
                            neg_r     <= req_a[DataWidth-1];
                            pre_step  <= 1'b0;
`endif
                            if (req_b == '0) begin
                                state      <= DONE;
                                resp_valid <= 1'b1;
                                if (is_mul_op(req_op))
                                    resp_data <= '0;
                                else if (is_rem_op(req_op))
                                    resp_data <= req_a;
                                else
                                    resp_data <= '1;
                            end else if (is_mul_op(req_op)) begin
                                state <= MUL_IT;
`ifdef MULDIV_SIGNED_EN
                            end else if (is_signed_op(req_op)) begin
                                state <= PRE;
`endif
                            end else begin
                                state <= DIV_CMP;
                            end
                        end
                    end
                    MUL_IT: begin
                        if (mplier[0])
                            acc <= alu_result;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (mplier[DataWidth-1:1] == '0) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= mplier[0] ? alu_result : acc;
                        end
                    end
                    DIV_CMP: begin
                        rem   <= shift_in;
                        top   <= rem[DataWidth-1];
                        lt    <= alu_result[0];
                        q     <= q << 1;
                        state <= DIV_SUB;
                    end
                    DIV_SUB: begin
                        if (do_sub) begin
                            rem  <= alu_result;
                            q[0] <= 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CntW'(DataWidth - 1)) begin
`ifdef MULDIV_SIGNED_EN
                            if (op_signed) begin
                                state <= POST;
                            end else begin
`endif
                                state      <= DONE;
                                resp_valid <= 1'b1;
                                if (op_rem)
                                    resp_data <= do_sub ? alu_result : rem;
                                else
                                    resp_data <= {q[DataWidth-1:1], do_sub};
`ifdef MULDIV_SIGNED_EN
                            end
`endif
                        end else begin
                            state <= DIV_CMP;
                        end
                    end
`ifdef MULDIV_SIGNED_EN
                    PRE: begin
                        if (!pre_step) begin
                            if (neg_r)
                                q <= alu_result;
                            pre_step <= 1'b1;
                        end else begin
                            if (divisor[DataWidth-1])
                                divisor <= alu_result;
                            state <= DIV_CMP;
                        end
                    end
                    POST: begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= post_neg ? alu_result : post_sel;
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Self-checking bench for muldiv_seq. A behavioural ALU closes the loop on
// alu_*; each accepted request pushes its expected result onto a
// scoreboard queue that the response monitor pops on resp_valid.
// Signed cases are compiled only with MULDIV_SIGNED_EN.

module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    typedef struct {
        logic [31:0] data;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic [3:0]  pipe_func;
    logic [31:0] pipe_op1, pipe_op2;
    logic [3:0]  alu_func;
    logic [31:0] alu_op1, alu_op2;
    logic [31:0] alu_result;

    exp_t        sbq[$];
    exp_t        popped;
    int          assertCount;
    int          failCount;
    logic [31:0] lastData;
    logic [31:0] ra, rb;

    muldiv_seq #(.DataWidth(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .pipe_func  (pipe_func),
        .pipe_op1   (pipe_op1),
        .pipe_op2   (pipe_op2),
        .alu_func   (alu_func),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result)
    );

    // Behavioural model of the shared execute-stage ALU.
    assign alu_result = (alu_func == ALU_ADD)  ? alu_op1 + alu_op2 :
                        (alu_func == ALU_SUB)  ? alu_op1 - alu_op2 :
                        (alu_func == ALU_SLTU) ? {31'd0, alu_op1 < alu_op2} :
                        32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                popped = sbq.pop_front();
                checkOutput({popped.tag, " data"}, resp_data, popped.data);
            end
        end
    end

    // Multiply latency in edges counted from the accept edge inclusive.
    function automatic int mulLat(input logic [31:0] b);
        int l;
        l = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) l = i + 2;
        return l;
    endfunction

    // Issue one request, push its expectation, then measure the latency
    // to resp_valid and confirm the pulse lasts one cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expData,
                                 input int expLat, input string tag);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        e.data = expData;
        e.tag  = tag;
        sbq.push_back(e);
        #1 req_valid = 1'b0;
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'(expLat));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " pulse"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
        lastData = expData;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        lastData    = 32'd0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_op      = OP_MUL;
        req_a       = 32'd0;
        req_b       = 32'd0;
        pipe_func   = ALU_ZERO;
        pipe_op1    = 32'd0;
        pipe_op2    = 32'd0;

        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_data", resp_data, 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        pipe_func = ALU_ADD;
        pipe_op1  = 32'd3;
        pipe_op2  = 32'd4;
        #1;
        checkOutput("pass func", 32'(alu_func), 32'(ALU_ADD));
        checkOutput("pass op1", alu_op1, 32'd3);
        checkOutput("pass op2", alu_op2, 32'd4);
        checkOutput("pass result", alu_result, 32'd7);

        applyStimulus(OP_MUL, 32'd7, 32'd6, 32'd42, 4, "mul_7x6");
        applyStimulus(OP_MUL, 32'h80000001, 32'd2, 32'h00000002, 3, "mul_wrap");
        applyStimulus(OP_MUL, 32'd1234, 32'd0, 32'd0, 1, "mul_by0");
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 65, "divu_100_7");
        applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2, 65, "remu_100_7");
        applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 65, "divu_max_1");
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
        applyStimulus(OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_by0");

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            applyStimulus(OP_MUL, ra, rb, ra * rb, mulLat(rb), "mul_rand");
            if (rb == 32'd0) rb = 32'd3;
            applyStimulus(OP_DIVU, ra, rb, ra / rb, 65, "divu_rand");
            applyStimulus(OP_REMU, ra, rb, ra % rb, 65, "remu_rand");
        end

`ifdef MULDIV_SIGNED_EN
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 68, "div_m7_2");
        applyStimulus(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 68, "rem_m7_2");
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 68, "div_ovf");
        applyStimulus(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 68, "rem_ovf");
        applyStimulus(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 68, "div_100_m7");
        applyStimulus(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by0");
        applyStimulus(OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, "rem_by0");
`else
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd14, 65, "op4_as_divu");
        applyStimulus(OP_REM, 32'd100, 32'd7, 32'd2, 65, "op5_as_remu");
`endif

        // Flush in the middle of a divide: no response, back to IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pipe_func = ALU_ADD;
        @(negedge clk);
        checkOutput("busy ignores pipe", 32'(alu_func), 32'(ALU_SLTU));
        repeat (18) @(posedge clk);
        @(negedge clk);
        checkOutput("flush busy before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush idle", 32'(busy), 32'd0);
        checkOutput("flush ready", 32'(req_ready), 32'd1);
        checkOutput("flush no resp", 32'(resp_valid), 32'd0);
        checkOutput("flush held data", resp_data, lastData);

        // flush together with a request in IDLE blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'd5;
        req_b     = 32'd5;
        flush     = 1'b1;
        #1;
        checkOutput("flush blocks ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("flush no accept", 32'(busy), 32'd0);
        req_valid = 1'b0;
        flush     = 1'b0;

        applyStimulus(OP_MUL, 32'd3, 32'd3, 32'd9, 3, "mul_after_flush");

        // Asynchronous reset in the middle of a long multiply.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'h12345678;
        req_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst busy", 32'(busy), 32'd0);
        checkOutput("async rst resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("async rst resp_data", resp_data, 32'd0);
        checkOutput("async rst passthrough", 32'(alu_func), 32'(pipe_func));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_MUL, 32'd11, 32'd13, 32'd143, 5, "mul_after_reset");

        repeat (5) @(negedge clk);
        checkOutput("scoreboard empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
